// File: rtl/mips32_pkg.sv
// Shared encodings for the multi-cycle MIPS32 core: opcodes, functs, FSM states and ALU ops.
package mips32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips32_regfile.sv
// 32x32 register file: two async read ports, one sync write port, $0 reads as zero.
// Latency: reads combinational, write visible the cycle after we; no backpressure.
module mips32_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips32_multicycle_core.sv
// Multi-cycle MIPS32 core on one unified memory port; 2-5 cycles per instruction at zero wait.
// Backpressure: mem_ready low freezes the FSM with request outputs held stable until accepted.
module mips32_multicycle_core
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted
);

  state_t      state, state_nxt;
  alu_op_t     alu_op;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] pc_nxt, rd1, rd2, alu_src, alu_res, imm_sext, br_target, jmp_target, wd;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic        pc_ld, ir_ld, ab_ld, alu_ld, mdr_ld, rf_we, legal, accept;
  logic        unused_shamt;

  assign opcode       = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign unused_shamt = ^ir[10:6];
  assign imm_sext     = sext16(ir[15:0]);
  // pc already points past the current instruction in every state after FETCH
  assign br_target    = pc + (imm_sext << 2);
  assign jmp_target   = {pc[31:28], ir[25:0], 2'b00};

  mips32_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (rf_we),
    .wa  (wa),
    .wd  (wd)
  );

  assign wa = (opcode == OP_RTYPE) ? rd : rt;
  assign wd = (opcode == OP_LW) ? mdr : alu_out;

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_SLT:          alu_op = ALU_SLT;
          default:         legal  = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign alu_src = (opcode == OP_RTYPE) ? b : imm_sext;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_res = a - alu_src;
      ALU_AND: alu_res = a & alu_src;
      ALU_OR:  alu_res = a | alu_src;
      ALU_SLT: alu_res = {31'd0, $signed(a) < $signed(alu_src)};
      default: alu_res = a + alu_src;
    endcase
  end

  // Outputs depend only on registered state, so they cannot move during a wait
  assign mem_req   = !rst && (state == FETCH || state == MEM);
  assign mem_we    = (state == MEM) && (opcode == OP_SW);
  assign mem_addr  = (state == MEM) ? {alu_out[31:2], 2'b00} : {pc[31:2], 2'b00};
  assign mem_wdata = b;
  assign accept    = mem_req && mem_ready;
  assign halted    = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc + 32'd4;
    pc_ld     = 1'b0;
    ir_ld     = 1'b0;
    ab_ld     = 1'b0;
    alu_ld    = 1'b0;
    mdr_ld    = 1'b0;
    rf_we     = 1'b0;
    case (state)
      FETCH: begin
        if (accept) begin
          ir_ld     = 1'b1;
          pc_ld     = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        ab_ld = 1'b1;
        if (!legal) begin
          state_nxt = HALT_ON_ILLEGAL ? HALT : FETCH;
        end else if (opcode == OP_J) begin
          pc_ld     = 1'b1;
          pc_nxt    = jmp_target;
          state_nxt = FETCH;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        alu_ld = 1'b1;
        if (opcode == OP_BEQ) begin
          pc_ld     = (a == b);
          pc_nxt    = br_target;
          state_nxt = FETCH;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_nxt = MEM;
        end else begin
          state_nxt = WB;
        end
      end
      MEM: begin
        if (accept) begin
          mdr_ld    = (opcode == OP_LW);
          state_nxt = (opcode == OP_SW) ? FETCH : WB;
        end
      end
      WB: begin
        rf_we     = 1'b1;
        state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (pc_ld)  pc      <= pc_nxt;
      if (ir_ld)  ir      <= mem_rdata;
      if (ab_ld) begin
        a <= rd1;
        b <= rd2;
      end
      if (alu_ld) alu_out <= alu_res;
      if (mdr_ld) mdr     <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mips32_multicycle_core.sv
// Directed bench: halting core at RESET_PC 0x100 with a wait-state memory, plus a NOP-mode core at 0x1000_0000.
module tb_mips32_multicycle_core;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_req2, mem_we2, mem_ready2, halted2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;

  mips32_multicycle_core #(.RESET_PC(32'h0000_0100), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted)
  );

  mips32_multicycle_core #(.RESET_PC(32'h1000_0000), .HALT_ON_ILLEGAL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2), .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem  [0:1023];
  logic [31:0] mem2 [0:255];
  logic        ld_en, hold, log_clr;
  logic [9:0]  ld_idx;
  logic [31:0] ld_dat;
  int          delay;
  int          wcnt = 0;
  int          cyc = 0;
  logic [31:0] tx_addr [0:63];
  logic [31:0] tx_dat  [0:63];
  logic        tx_we   [0:63];
  int          tx_cyc  [0:63];
  int          tx_n = 0;
  logic [31:0] t2_addr [0:63];
  int          t2_cyc  [0:63];
  int          t2_n = 0;
  logic        prev_wait = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;
  logic        unstable = 1'b0;
  int          nvec = 0;
  int          nerr = 0;

  assign mem_ready  = !hold && (wcnt >= delay);
  assign mem_rdata  = mem[mem_addr[11:2]];
  assign mem_ready2 = 1'b1;
  assign mem_rdata2 = mem2[mem_addr2[9:2]];

  // Memory models, transaction logs and request-stability monitor
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wcnt <= (rst || !mem_req || mem_ready) ? 0 : wcnt + 1;
    if (ld_en) mem[ld_idx] <= ld_dat;
    if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      if (tx_n < 64) begin
        tx_addr[tx_n] <= mem_addr;
        tx_we[tx_n]   <= mem_we;
        tx_dat[tx_n]  <= mem_we ? mem_wdata : mem_rdata;
        tx_cyc[tx_n]  <= cyc;
        tx_n          <= tx_n + 1;
      end
    end
    if (mem_req2 && mem_ready2 && t2_n < 64) begin
      t2_addr[t2_n] <= mem_addr2;
      t2_cyc[t2_n]  <= cyc;
      t2_n          <= t2_n + 1;
    end
    if (!rst && prev_wait && (!mem_req || mem_addr != prev_addr || mem_we != prev_we ||
                              (prev_we && mem_wdata != prev_wdata)))
      unstable <= 1'b1;
    prev_wait  <= mem_req && !mem_ready;
    prev_addr  <= mem_addr;
    prev_we    <= mem_we;
    prev_wdata <= mem_wdata;
    if (log_clr) begin
      tx_n     <= 0;
      t2_n     <= 0;
      unstable <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] dat);
    ld_en  = 1'b1;
    ld_idx = addr[11:2];
    ld_dat = dat;
    tick();
    ld_en  = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int lim);
    int n;
    n = 0;
    while (!halted && n < lim) begin
      tick();
      n++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found, req_seen;
    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_dat = '0;
    hold = 1'b0; delay = 0; log_clr = 1'b1;
    for (int i = 0; i < 256; i++) mem2[i] = 32'h0;
    mem2[0]  = ej(26'h40);             // j 0x40 -> 0x1000_0100
    mem2[64] = 32'hFC00_0000;          // illegal, NOP mode
    mem2[65] = ej(26'h41);             // spin at 0x1000_0104

    // ---- Phase A: reset, arithmetic, sw/lw, $0, branches, halt ----
    load(32'h100, ei(6'h08, 0, 1, 16'd5));
    load(32'h104, ei(6'h08, 0, 2, 16'hFFF9));
    load(32'h108, er(1, 2, 3, 6'h20));
    load(32'h10C, er(2, 1, 4, 6'h2A));
    load(32'h110, er(0, 1, 5, 6'h22));
    load(32'h114, ei(6'h2B, 0, 3, 16'h200));
    load(32'h118, ei(6'h2B, 0, 4, 16'h204));
    load(32'h11C, ei(6'h2B, 0, 5, 16'h208));
    load(32'h120, ei(6'h2B, 0, 1, 16'h008));
    load(32'h124, ei(6'h23, 0, 6, 16'h008));
    load(32'h128, ei(6'h2B, 0, 6, 16'h20C));
    load(32'h12C, ei(6'h08, 0, 0, 16'd9));
    load(32'h130, ei(6'h2B, 0, 0, 16'h210));
    load(32'h134, ei(6'h04, 1, 2, 16'd5));
    load(32'h138, ej(26'd8));
    load(32'h020, ei(6'h04, 0, 0, 16'hFFFE));
    load(32'h01C, 32'hFC00_0000);
    load(32'h210, 32'hDEAD_BEEF);
    chk("rst_req_low", 32'(mem_req), 32'd0);
    chk("rst_halted_low", 32'(halted), 32'd0);
    rst = 1'b0; log_clr = 1'b0;
    #1;
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_we", 32'(mem_we), 32'd0);
    chk("first_addr", mem_addr, 32'h100);
    wait_halt("halt_on_illegal", 300);
    req_seen = 1'b0;
    repeat (10) begin
      tick();
      if (mem_req) req_seen = 1'b1;
    end
    chk("halt_no_req", 32'(req_seen), 32'd0);
    chk("halt_tx_count", tx_n, 32'd24);
    chk("addi_cycles", tx_cyc[1] - tx_cyc[0], 32'd4);
    chk("slt_cycles", tx_cyc[4] - tx_cyc[3], 32'd4);
    chk("sw_cycles", tx_cyc[7] - tx_cyc[5], 32'd4);
    chk("sw8_addr", tx_addr[12], 32'h8);
    chk("sw8_we", 32'(tx_we[12]), 32'd1);
    chk("sw8_data", tx_dat[12], 32'd5);
    chk("lw_cycles", tx_cyc[15] - tx_cyc[13], 32'd5);
    chk("add_result", mem[128], 32'hFFFF_FFFE);
    chk("slt_result", mem[129], 32'h1);
    chk("sub_result", mem[130], 32'hFFFF_FFFB);
    chk("lw_result", mem[131], 32'd5);
    chk("r0_stays_zero", mem[132], 32'h0);
    chk("beq_nt_target", tx_addr[21], 32'h138);
    chk("beq_nt_cycles", tx_cyc[21] - tx_cyc[20], 32'd3);
    chk("j_target", tx_addr[22], 32'h20);
    chk("j_cycles", tx_cyc[22] - tx_cyc[21], 32'd2);
    chk("beq_t_target", tx_addr[23], 32'h1C);
    chk("beq_t_cycles", tx_cyc[23] - tx_cyc[22], 32'd3);
    chk("j_hi_first", t2_addr[0], 32'h1000_0000);
    chk("j_hi_target", t2_addr[1], 32'h1000_0100);
    chk("j_hi_cycles", t2_cyc[1] - t2_cyc[0], 32'd2);
    chk("nop_next_pc", t2_addr[2], 32'h1000_0104);
    chk("nop_cycles", t2_cyc[2] - t2_cyc[1], 32'd2);
    chk("nop_not_halted", 32'(halted2), 32'd0);

    // ---- Phase B: lw and sw with 3 wait states per access ----
    rst = 1'b1; log_clr = 1'b1; delay = 3;
    load(32'h100, ei(6'h23, 0, 7, 16'h008));
    load(32'h104, ei(6'h2B, 0, 7, 16'h214));
    load(32'h108, 32'hFC00_0000);
    rst = 1'b0; log_clr = 1'b0;
    wait_halt("wait_halt", 300);
    chk("wait_lw_cycles", tx_cyc[2] - tx_cyc[0], 32'd11);
    chk("wait_sw_data", tx_dat[3], 32'd5);
    chk("wait_sw_mem", mem[133], 32'd5);
    chk("wait_stable", 32'(unstable), 32'd0);

    // ---- Phase C: reset while lw stalls in MEM ----
    rst = 1'b1; log_clr = 1'b1; delay = 0;
    load(32'h100, ei(6'h08, 0, 1, 16'd3));
    load(32'h104, ei(6'h23, 0, 1, 16'h008));
    load(32'h218, 32'hDEAD_BEEF);
    rst = 1'b0; log_clr = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      tick();
      if (mem_req && !mem_we && mem_addr == 32'h8) found = 1'b1;
    end
    hold = 1'b1;
    chk("lw_reached_mem", 32'(found), 32'd1);
    repeat (3) tick();
    chk("stall_addr", mem_addr, 32'h8);
    rst = 1'b1; log_clr = 1'b1;
    #1;
    chk("rst_drops_req", 32'(mem_req), 32'd0);
    tick();
    hold = 1'b0;
    load(32'h100, ei(6'h2B, 0, 1, 16'h218));
    load(32'h104, 32'hFC00_0000);
    rst = 1'b0; log_clr = 1'b0;
    #1;
    chk("refetch_addr", mem_addr, 32'h100);
    chk("refetch_req", 32'(mem_req), 32'd1);
    wait_halt("rst_stall_halt", 100);
    chk("rt_after_abort", mem[134], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
